// File: rtl/keypad_pkg.sv
// Shared constants and bit-vector helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int CODE_W   = 4;
    localparam int FRAME_W  = NUM_COLS * NUM_ROWS;
    localparam int STABLE_W = 4;

    // One full-matrix snapshot; bit index = col*NUM_ROWS + row, 1 = pressed.
    typedef logic [FRAME_W-1:0] frame_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [CODE_W-1:0] lowest_set_idx(input frame_t v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = FRAME_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // True when two or more bits are set (clearing the lowest bit leaves something).
    function automatic logic more_than_one(input frame_t v);
        return (v & (v - FRAME_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad header and key-report signals bundled between board, scanner and user logic.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;          // raw rows, active-low, asynchronous
    logic [NUM_COLS-1:0] col;          // column drive, active-low, one-hot-low
    logic [CODE_W-1:0]   key_code;     // debounced code of the lowest pressed key
    logic                key_down;     // at least one key held
    logic                multi_key;    // more than one key held
    logic                key_press;    // one-clk strobe on a new key
    logic                key_release;  // one-clk strobe when everything is released

    // Scanner side: samples rows, drives columns and the key report.
    modport master (
        input  row,
        output col, key_code, key_down, multi_key, key_press, key_release
    );

    // Board/user side: supplies rows, observes columns and the key report.
    modport slave (
        output row,
        input  col, key_code, key_down, multi_key, key_press, key_release
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clk scan enable every 2^DIV_BIT cycles.
module scan_tick_gen #(
    parameter int DIV_BIT = 14
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV_BIT-1:0] div_q;
    logic [DIV_BIT-1:0] div_d;

    // Next divider value; the natural wrap at all-ones returns it to 0.
    always_comb begin
        div_d = div_q + DIV_BIT'(1);
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Terminal count marks the scan step.
    assign tick = &div_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: column-at-a-time drive, whole-frame debounce,
// single-code report with press/release strobes, all in the clk domain.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DIV_BIT    = 14,
    parameter int DEB_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    keypad_scanner_if.master        bus
);

    localparam logic [STABLE_W-1:0] DEB_CNT  = STABLE_W'(DEB_FRAMES);
    localparam logic [1:0]          LAST_COL = 2'(NUM_COLS - 1);

    logic tick;

    // Row synchroniser; idles at all-ones (no key pressed).
    logic [NUM_ROWS-1:0] sync1_q, sync1_d;
    logic [NUM_ROWS-1:0] sync2_q, sync2_d;
    logic [NUM_ROWS-1:0] rs;

    // Scan and debounce state.
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    frame_t              frame_q, frame_d;
    frame_t              prev_q, prev_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    frame_t              deb_q, deb_d;
    frame_t              frame_now;

    // Registered key report.
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_down_q, key_down_d;
    logic                multi_q, multi_d;
    logic                press_q, press_d;
    logic                release_q, release_d;

    scan_tick_gen #(
        .DIV_BIT (DIV_BIT)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser; rs is active-high pressed.
    always_comb begin
        sync1_d = bus.row;
        sync2_d = sync1_q;
        rs      = ~sync2_q;
    end

    // Per-tick column sampling, column advance and frame-end debounce.
    always_comb begin
        frame_d   = frame_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        deb_d     = deb_q;

        // Frame including the rows of the column currently driven.
        frame_now = frame_q;
        frame_now[col_idx_q*NUM_ROWS +: NUM_ROWS] = rs;

        if (tick) begin
            // Rows are captured before the column moves, so each column
            // has had a full tick period to settle.
            frame_d   = frame_now;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = ~(NUM_COLS'(1) << col_idx_d);

            if (col_idx_q == LAST_COL) begin
                if (frame_now == prev_q) begin
                    if (stable_q < DEB_CNT) begin
                        stable_d = stable_q + STABLE_W'(1);
                    end
                end else begin
                    stable_d = STABLE_W'(1);
                end
                prev_d = frame_now;

                if ((stable_d == DEB_CNT) && (frame_now != deb_q)) begin
                    deb_d = frame_now;
                end
            end
        end
    end

    // Key report derived from the debounced matrix; the previous report
    // stands in for the old debounced value when forming the strobes.
    always_comb begin
        key_down_d = |deb_q;
        multi_d    = more_than_one(deb_q);
        key_code_d = key_code_q;
        press_d    = 1'b0;
        release_d  = 1'b0;

        if (|deb_q) begin
            key_code_d = lowest_set_idx(deb_q);
            press_d    = !key_down_q || (lowest_set_idx(deb_q) != key_code_q);
        end else begin
            release_d  = key_down_q;
        end
    end

    // State registers; everything returns to the idle, column-0 state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            col_idx_q  <= '0;
            col_q      <= 4'b1110;
            frame_q    <= '0;
            prev_q     <= '0;
            stable_q   <= '0;
            deb_q      <= '0;
            key_code_q <= '0;
            key_down_q <= 1'b0;
            multi_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            frame_q    <= frame_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            deb_q      <= deb_d;
            key_code_q <= key_code_d;
            key_down_q <= key_down_d;
            multi_q    <= multi_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    assign bus.col         = col_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_down    = key_down_q;
    assign bus.multi_key   = multi_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;

endmodule
